// File: rtl/eim_seq_pkg.sv
// Shared types and constants for the time-multiplexed 8x8 EIM sequencer.
package eim_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } eim_state_e;

   localparam int EIM_SEQ_STEPS = 4;
   localparam int EIM_SEQ_WIDTH = 8;
   localparam int EIM_SEQ_HALF  = EIM_SEQ_WIDTH / 2;

   localparam logic [3:0] EIM_SEQ_SH_LL = 4'd0;
   localparam logic [3:0] EIM_SEQ_SH_HL = 4'd4;
   localparam logic [3:0] EIM_SEQ_SH_LH = 4'd4;
   localparam logic [3:0] EIM_SEQ_SH_HH = 4'd8;

   // Alignment of the nibble product accumulated at a given step.
   function automatic logic [3:0] eim_seq_shift(input logic [1:0] step);
      case (step)
         2'd0:    return EIM_SEQ_SH_LL;
         2'd1:    return EIM_SEQ_SH_HL;
         2'd2:    return EIM_SEQ_SH_LH;
         2'd3:    return EIM_SEQ_SH_HH;
         default: return EIM_SEQ_SH_LL;
      endcase
   endfunction

endpackage

// File: rtl/EIM4x4.sv
// 4x4 unsigned partial-product multiplier shared by the 8x8 sequencer.
module EIM4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/eim8x8_seq.sv
// 8x8 multiplier stepping four nibble products through one EIM4x4.
// Optional: define EIM_SEQ_ZERO_SKIP_EN to short-cut zero operands straight to DONE.
module eim8x8_seq
   import eim_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_r,
   output logic                 busy
);

   localparam int HALF = EIM_SEQ_HALF;

   eim_state_e             state_r;
   eim_state_e             state_nxt_s;
   logic [1:0]             step_r;
   logic [WIDTH-1:0]       a_r;
   logic [WIDTH-1:0]       b_r;
   logic [2*WIDTH-1:0]     acc_r;
   logic [HALF-1:0]        nib_a_s;
   logic [HALF-1:0]        nib_b_s;
   logic [WIDTH-1:0]       prod_s;
   logic [2*WIDTH-1:0]     addend_s;
   logic                   last_step_s;
   logic                   zero_s;

`ifdef EIM_SEQ_ZERO_SKIP_EN
   assign zero_s = (in_a == {WIDTH{1'b0}}) || (in_b == {WIDTH{1'b0}});
`else
   assign zero_s = 1'b0;
`endif

   assign last_step_s = (step_r == 2'(EIM_SEQ_STEPS - 1));

   // Nibble selection for the shared multiplier, indexed by step.
   always_comb begin
      nib_a_s = a_r[HALF-1:0];
      nib_b_s = b_r[HALF-1:0];
      case (step_r)
         2'd0: begin nib_a_s = a_r[HALF-1:0];     nib_b_s = b_r[HALF-1:0];     end
         2'd1: begin nib_a_s = a_r[WIDTH-1:HALF]; nib_b_s = b_r[HALF-1:0];     end
         2'd2: begin nib_a_s = a_r[HALF-1:0];     nib_b_s = b_r[WIDTH-1:HALF]; end
         2'd3: begin nib_a_s = a_r[WIDTH-1:HALF]; nib_b_s = b_r[WIDTH-1:HALF]; end
         default: begin nib_a_s = a_r[HALF-1:0];  nib_b_s = b_r[HALF-1:0];     end
      endcase
   end

   EIM4x4 u_eim4x4 (
      .a (nib_a_s),
      .b (nib_b_s),
      .p (prod_s)
   );

   assign addend_s = {{WIDTH{1'b0}}, prod_s} << eim_seq_shift(step_r);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt_s = zero_s ? ST_DONE : ST_MUL;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (last_step_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_MUL;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded purely from the registered state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_r)
         ST_IDLE: begin in_ready = 1'b1; out_valid = 1'b0; busy = 1'b0; end
         ST_MUL:  begin in_ready = 1'b0; out_valid = 1'b0; busy = 1'b1; end
         ST_DONE: begin in_ready = 1'b0; out_valid = 1'b1; busy = 1'b1; end
         default: begin in_ready = 1'b0; out_valid = 1'b0; busy = 1'b1; end
      endcase
   end

   // Operand capture, step counter and modulo-2^16 accumulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_r <= 2'd0;
         a_r    <= {WIDTH{1'b0}};
         b_r    <= {WIDTH{1'b0}};
         acc_r  <= {(2*WIDTH){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r    <= in_a;
                  b_r    <= in_b;
                  acc_r  <= {(2*WIDTH){1'b0}};
                  step_r <= 2'd0;
               end
            end
            ST_MUL: begin
               acc_r  <= acc_r + addend_s;
               step_r <= step_r + 2'd1;
            end
            default: acc_r <= acc_r;
         endcase
      end
   end

   assign out_r = acc_r;

endmodule

// File: tb/tb_eim8x8_seq.sv
// Scoreboard bench for eim8x8_seq: stimulus pushes expected products, a monitor checks them.
module tb_eim8x8_seq;

`ifdef EIM_SEQ_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = 8'h00;
   logic [7:0]  in_b = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_r;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] exp_q[$];
   int          lat_q[$];
   int          pend_acc_q[$];
   int          accept_q[$];

   logic        prev_valid = 1'b0;
   logic [15:0] held = 16'h0000;

   eim8x8_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned product reduced modulo 2^16.
   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int unsigned prod;
      prod = int'(a) * int'(b);
      return 16'(prod % 65536);
   endfunction

   // Monitor: records accepts and checks every presented result against the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_mul(in_a, in_b));
            lat_q.push_back((SKIP && (in_a == 8'h00 || in_b == 8'h00)) ? 1 : 4);
            pend_acc_q.push_back(cyc + 1);
            accept_q.push_back(cyc + 1);
         end
         if (out_valid) begin
            if (!prev_valid) begin
               check("result_pending", {31'd0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  check("out_r", {16'd0, out_r}, {16'd0, exp_q[0]});
                  check("latency", cyc - pend_acc_q[0], lat_q[0]);
               end
               held <= out_r;
            end else begin
               check("out_r_stable", {16'd0, out_r}, {16'd0, held});
               check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
            end
            if (out_ready && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               void'(lat_q.pop_front());
               void'(pend_acc_q.pop_front());
            end
            prev_valid <= !out_ready;
         end else begin
            prev_valid <= 1'b0;
         end
      end
   end

   task automatic wait_accept(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (in_valid && in_ready && rst_n) got = 1'b1;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         check({name, "_accept_timeout"}, 32'd0, 32'd1);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input string name);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      wait_accept(name);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      if (!got) check({name, "_valid_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      check({name, "_drain"}, exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int n0;
      int base;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_r", {16'd0, out_r}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Exact path
      out_ready = 1'b1;
      send(8'hFF, 8'hFF, "exact");
      drain("exact");

      // Backpressure
      out_ready = 1'b0;
      send(8'h3C, 8'hA5, "bp");
      wait_valid("bp");
      @(posedge clk);
      #1;
      n0 = accept_q.size();
      in_a = 8'h11;
      in_b = 8'h22;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      check("bp_no_accept", accept_q.size(), n0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_idle_busy", {31'd0, busy}, 32'd0);
      drain("bp");

      // Zero operand, then single-step nibble patterns
      send(8'h00, 8'h7E, "zero");
      drain("zero");
      send(8'hF0, 8'h0F, "nib_hl");
      drain("nib_hl");
      send(8'h0F, 8'hF0, "nib_lh");
      drain("nib_lh");

      // Reset during step 2
      send(8'h55, 8'hAA, "rst_mid");
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_out_r", {16'd0, out_r}, 32'd0);
      exp_q.delete();
      lat_q.delete();
      pend_acc_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      send(8'h12, 8'h34, "after_rst");
      drain("after_rst");

      // Back-to-back with in_valid held high
      out_ready = 1'b1;
      base = accept_q.size();
      in_a = 8'($urandom_range(1, 255));
      in_b = 8'($urandom_range(1, 255));
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_accept("b2b");
         if (i < 7) begin
            in_a = 8'($urandom_range(1, 255));
            in_b = 8'($urandom_range(1, 255));
         end else begin
            in_valid = 1'b0;
         end
      end
      for (int i = 1; i < 8; i++) begin
         if (accept_q.size() > base + i)
            check("b2b_spacing", accept_q[base+i] - accept_q[base+i-1], 32'd6);
         else
            check("b2b_accept_count", accept_q.size(), base + 8);
      end
      drain("b2b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eim8x8_seq.md
# eim8x8_seq

Time-multiplexed sequencer for 8x8 multiplication that reuses one `EIM4x4` partial-product multiplier over four cycles instead of four parallel instances. It accepts one operand pair over a valid/ready handshake and steps the four nibble products through the shared `EIM4x4`. It accumulates them with the same shifts and modulo-2^16 sum as the combinational `EIM8x8`, then presents the 16-bit result over a second valid/ready handshake. It sits in area-constrained PE variants of the APTPU array, where the multiplier is shared and throughput is traded for area.

## Interface
- `WIDTH`, default 8: operand width. Only 8 is supported; the half width is `WIDTH/2` = 4.
- `clk` input, 1 bit: single clock, all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: operand pair present.
- `in_ready` output, 1 bit: block can accept an operand pair.
- `in_a` input, `WIDTH` bits: multiplicand A, unsigned.
- `in_b` input, `WIDTH` bits: multiplier B, unsigned.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_r` output, `2*WIDTH` bits: product R.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL: 2-bit `step` counter runs 0..3.
  - DONE: `out_valid`=1.
- Accept: when IDLE and `in_valid`=1, latch `in_a`/`in_b` into operand registers, clear the accumulator, set `step`=0 and go to MUL. Operands are ignored in every other state.
- Each MUL cycle selects the nibble pair and shift by `step`, then does `acc <= acc + (p << shift)`, where `p` is the `EIM4x4` output:
  - step 0: AL·BL, shift 0
  - step 1: AH·BL, shift 4
  - step 2: AL·BH, shift 4
  - step 3: AH·BH, shift 8
- Arithmetic: the accumulator is 16 bits. Every addition is truncated modulo 2^16, so the result is bit-identical to the combinational `EIM8x8` for the same `EIM4x4`.
- Step 3 completes and the state moves to DONE. `out_r` = `acc`.
- DONE: `out_valid`=1, and `out_r` holds stable until `out_ready`=1. Then go to IDLE.
- Backpressure: the block stays in DONE indefinitely while `out_ready`=0. `in_ready` stays 0 throughout.
- `out_ready` asserted outside DONE has no effect.
- Reset values: state IDLE, `step`=0, accumulator and operand registers 0, `out_r`=0, `out_valid`=0, `busy`=0. `in_ready`=1 once reset is released.
- Reset mid-operation, in MUL or DONE: the in-flight result is discarded and no output handshake occurs for it.

## Timing
- Accept at edge T. Accumulation happens at edges T+1..T+4. `out_valid` is high from T+4 onward.
  - Latency: 4 cycles from accept to `out_valid`.
- With `out_ready` tied to 1: DONE lasts 1 cycle and IDLE lasts 1 cycle. Minimum accept-to-accept spacing is 6 cycles.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from the input signals.
- The `EIM4x4` input muxes are combinational from `step` and the operand registers; the product is consumed in the same cycle.

## Configuration
- `EIM_SEQ_ZERO_SKIP_EN` defined: if `in_a`==0 or `in_b`==0 at accept, go directly to DONE with `acc`=0.
  - `out_valid` is high from T+1, so latency is 1 cycle.
  - Nonzero operands take the normal 4-step path.
- Not defined: every operand pair takes 4 MUL cycles, including zero operands.

## Structure
- Package `eim_seq_pkg` holds:
  - state encoding: IDLE, MUL, DONE
  - `EIM_SEQ_STEPS`=4
  - `EIM_SEQ_HALF`=`WIDTH/2`
  - shift-per-step constants 0, 4, 4, 8
- Exactly one sub-module instance: `EIM4x4`, with inputs driven by the step-indexed nibble muxes.
- No other submodules. FSM, counter and accumulator are in this module.

## Test plan
- Exact-path check: A=0xFF, B=0xFF, `out_ready`=1.
  - `out_valid` exactly 4 cycles after accept.
  - `out_r` equals the combinational `EIM8x8` result; 0xFE01 with an exact `EIM4x4`.
- Backpressure: A=0x3C, B=0xA5, `out_ready`=0 for 10 cycles, then 1.
  - `out_r` stable and `out_valid`=1 throughout.
  - `in_ready`=0 throughout, and a new `in_valid` is not accepted.
  - IDLE the cycle after the handshake.
- Zero operand: A=0x00, B=0x7E.
  - With `EIM_SEQ_ZERO_SKIP_EN`: `out_r`=0, `out_valid` at T+1.
  - Without it: `out_r`=0, `out_valid` at T+4.
- Reset mid-operation: assert `rst_n`=0 asynchronously during step 2.
  - All outputs reset immediately; no `out_valid` for that operation.
  - The next pair, A=0x12, B=0x34, gives the reference result.
- Back-to-back: `in_valid` held high with 8 random pairs, `out_ready`=1.
  - Accepts spaced exactly 6 cycles apart.
  - Every `out_r` matches the combinational `EIM8x8` model in order.
- Nibble coverage: A=0xF0, B=0x0F, then A=0x0F, B=0xF0.
  - Each isolates a single nonzero step: step 1 (AH·BL) for the first pair, step 2 (AL·BH) for the second.
  - Results equal `EIM4x4`(0xF,0xF) << 4 in both cases.
